if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU. It owns the program counter and drives the word address into the combinational instruction ROM. It latches the returned instruction into the IF/ID pipeline register for the decode stage. It applies next-PC redirection (branch, jump, jr, exception vectors), stall and flush, and enforces the PC[31] supervisor-bit rules.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset (supervisor mode, ROM word 0)
- ILLOP_PC, 32'h8000_0004, illegal-instruction vector
- XADR_PC, 32'h8000_0008, interrupt/exception vector

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Stall  in  1  hold PC and IF/ID (load-use hazard from ID)
- Flush  in  1  replace IF/ID contents with a bubble (taken redirect from ID/EX)
- PCSrc  in  3  next-PC select: 0 PC+4, 1 BranchTarget, 2 jump, 3 jr, 4 ILLOP_PC, 5 XADR_PC, 6/7 treated as 4
- BranchTarget  in  32  branch target computed in ID
- JumpIndex  in  26  instr_index field of J/JAL
- JrTarget  in  32  register value for JR/JALR
- InstAddress  out  31  PC[30:0] to the instruction ROM (ROM indexes bits 9:2)
- Instruction  in  32  combinational ROM read data for InstAddress
- PC  out  32  current PC
- IF_ID_Instruction  out  32  latched instruction
- IF_ID_PCPlus4  out  32  PC+4 of latched instruction
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble
- FetchCount  out  32  number of valid instructions latched into IF/ID

## Operation
- PCPlus4 = {PC[31], PC[30:0] + 4}; the increment wraps within bits 30:0 and never carries into bit 31.
- Next-PC candidates; bits 1:0 are always forced to 00 on load:
  - 1: {PC[31], BranchTarget[30:0]}
  - 2: {PC[31], PCPlus4[30:28], JumpIndex, 2'b00}
  - 3: {PC[31] & JrTarget[31], JrTarget[30:0]}. JR may leave supervisor mode but cannot enter it.
  - 4 and 6/7: ILLOP_PC
  - 5: XADR_PC
- PC update:
  - reset: PC = RESET_PC.
  - Flush=1: PC loads the selected next PC, regardless of Stall.
  - Stall=1 and Flush=0: PC holds.
  - Otherwise: PC loads the selected next PC.
- IF/ID update, in priority order:
  - reset: Instruction=0, PCPlus4=0, Valid=0.
  - Flush=1: Instruction=32'h0 (nop), PCPlus4=0, Valid=0. Flush wins over Stall.
  - Stall=1: hold all fields.
  - Otherwise: Instruction=Instruction input, PCPlus4=PCPlus4, Valid=1.
- FetchCount:
  - Increments by 1 on each edge where IF/ID loads with Valid=1.
  - Wraps modulo 2^32.
  - Cleared by reset.
- InstAddress is PC[30:0] with no additional logic.

## Timing
- Outputs after reset: PC=RESET_PC, InstAddress=31'h0, IF/ID all zero, Valid=0, FetchCount=0.
- One-cycle fetch latency. The instruction at PC appears on IF_ID_Instruction one edge after PC is presented, provided there is no stall or flush.
- Redirect path: PCSrc/targets sampled at edge N set PC at N. The wrong-path instruction fetched during cycle N-1 must be killed by the controller asserting Flush together with the redirect.
- Stall held for k cycles freezes PC and IF/ID for k edges. Fetch resumes on the first edge with Stall=0.
- Stall and Flush together: PC redirects and IF/ID becomes a bubble; no fetch is lost.
- reset asserted mid-stall or mid-flush: reset wins on that edge and all state returns to reset values.
- PCSrc is ignored while Stall=1 and Flush=0.

## Test plan
- Reset then 4 free-running edges with no stall or flush -> IF_ID_PCPlus4 sequence 8000_0004, 8000_0008, 8000_000C, 8000_0010; Valid=1; FetchCount=4; first instruction = ROM word 0.
- At PC=8000_0008, Flush=1 and PCSrc=1 with BranchTarget=0000_0068 -> next PC=8000_0068, IF/ID is a bubble (Valid=0, instr 0), FetchCount does not increment; the following edge latches ROM word 26.
- Stall=1 for 3 edges at PC=8000_0010 -> PC, IF/ID and FetchCount are unchanged; after release, PC=8000_0014 on the next edge.
- From PC=8000_0040: PCSrc=3 with JrTarget=0000_0100 -> PC=0000_0100. Then PCSrc=3 with JrTarget=8000_0000 -> PC=0000_0000 (supervisor bit not set).
- From user PC=0000_0020: PCSrc=5 -> PC=8000_0008; PCSrc=7 -> PC=8000_0004. PCSrc=2 with JumpIndex=26'h1b -> PC=0000_006C.
- Stall=1 and Flush=1 with PCSrc=2 in the same cycle -> redirect taken and bubble inserted. Then assert reset during Stall=1 -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage of the pipelined MIPS CPU. Owns the
//            program counter, addresses the combinational instruction ROM,
//            and latches the returned word into the IF/ID pipeline register.
//            Applies next-PC redirection (branch, jump, jr, exception
//            vectors), stall and flush, and the PC[31] supervisor-bit rules.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            Stall, Flush        - hold / bubble controls from ID, ID/EX
//            PCSrc               - next-PC select (0..5, 6/7 alias 4)
//            BranchTarget,
//            JumpIndex, JrTarget - redirect targets
//            InstAddress         - PC[30:0] to the instruction ROM
//            Instruction         - ROM read data for InstAddress
//            PC                  - current program counter
//            IF_ID_*             - IF/ID pipeline register contents
//            FetchCount          - count of valid instructions latched
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrTarget,
    output logic [30:0] InstAddress,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] FetchCount
);

    localparam logic [2:0]  c_SEL_PLUS4  = 3'd0;
    localparam logic [2:0]  c_SEL_BRANCH = 3'd1;
    localparam logic [2:0]  c_SEL_JUMP   = 3'd2;
    localparam logic [2:0]  c_SEL_JR     = 3'd3;
    localparam logic [2:0]  c_SEL_XADR   = 3'd5;
    localparam logic [30:0] c_WORD_STEP  = 31'd4;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pcplus4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_raw;
    logic [31:0] w_next_pc;

    // The increment stays inside bits 30:0 so sequential fetch can never
    // change the supervisor bit.
    assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + c_WORD_STEP};

    always_comb begin
        w_next_raw = ILLOP_PC;
        case (PCSrc)
            c_SEL_PLUS4:  w_next_raw = w_pc_plus4;
            c_SEL_BRANCH: w_next_raw = {r_pc[31], BranchTarget[30:0]};
            c_SEL_JUMP:   w_next_raw = {r_pc[31], w_pc_plus4[30:28], JumpIndex, 2'b00};
            // JR may drop to user mode but can never raise the supervisor bit.
            c_SEL_JR:     w_next_raw = {r_pc[31] & JrTarget[31], JrTarget[30:0]};
            c_SEL_XADR:   w_next_raw = XADR_PC;
            default:      w_next_raw = ILLOP_PC;
        endcase
    end

    // Every loaded PC is word aligned, whatever the source supplied.
    assign w_next_pc = {w_next_raw[31:2], 2'b00};

    // Flush carries a redirect that must land even while ID is stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (Flush || !Stall) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_instr   <= 32'h0;
            r_ifid_pcplus4 <= 32'h0;
            r_ifid_valid   <= 1'b0;
            r_fetch_count  <= 32'h0;
        end else if (Flush) begin
            r_ifid_instr   <= 32'h0;
            r_ifid_pcplus4 <= 32'h0;
            r_ifid_valid   <= 1'b0;
        end else if (!Stall) begin
            r_ifid_instr   <= Instruction;
            r_ifid_pcplus4 <= w_pc_plus4;
            r_ifid_valid   <= 1'b1;
            r_fetch_count  <= r_fetch_count + 32'd1;
        end
    end

    assign InstAddress       = r_pc[30:0];
    assign PC                = r_pc;
    assign IF_ID_Instruction = r_ifid_instr;
    assign IF_ID_PCPlus4     = r_ifid_pcplus4;
    assign IF_ID_Valid       = r_ifid_valid;
    assign FetchCount        = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage. A small ROM array feeds the
//            DUT; a behavioural model computes the expected PC and IF/ID
//            state from the fetch rules; directed steps add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] c_ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] c_XADR_PC  = 32'h8000_0008;
    localparam logic [31:0] c_SUP      = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [2:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] JrTarget;
    logic [30:0] InstAddress;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [31:0] FetchCount;

    logic [31:0] rom [0:255];

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_started = 1'b0;

    if_stage #(
        .RESET_PC (c_RESET_PC),
        .ILLOP_PC (c_ILLOP_PC),
        .XADR_PC  (c_XADR_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .PCSrc             (PCSrc),
        .BranchTarget      (BranchTarget),
        .JumpIndex         (JumpIndex),
        .JrTarget          (JrTarget),
        .InstAddress       (InstAddress),
        .Instruction       (Instruction),
        .PC                (PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .FetchCount        (FetchCount)
    );

    always #5 clk = ~clk;

    assign Instruction = rom[InstAddress[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequential PC+4 adds 4 to the word address but keeps bit 31 as-is.
    function automatic logic [31:0] plus4(input logic [31:0] pc);
        return (pc & c_SUP) | ((pc + 32'd4) & ~c_SUP);
    endfunction

    function automatic logic [31:0] target(input logic [31:0] pc, input logic [2:0] sel,
                                           input logic [31:0] bt, input logic [25:0] ji,
                                           input logic [31:0] jr);
        logic [31:0] t;
        case (sel)
            3'd0:    t = plus4(pc);
            3'd1:    t = (pc & c_SUP) | (bt & ~c_SUP);
            3'd2:    t = (pc & c_SUP) | (plus4(pc) & 32'h7000_0000) | ({6'd0, ji} * 4);
            3'd3:    t = (pc & jr & c_SUP) | (jr & ~c_SUP);
            3'd5:    t = c_XADR_PC;
            default: t = c_ILLOP_PC;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        logic [31:0] ins;
        logic [31:0] p4;
        nxt = target(m_pc, PCSrc, BranchTarget, JumpIndex, JrTarget);
        ins = rom[m_pc[9:2]];
        p4  = plus4(m_pc);
        if (reset) begin
            m_pc      = c_RESET_PC;
            m_instr   = 32'h0;
            m_pcp4    = 32'h0;
            m_valid   = 1'b0;
            m_count   = 32'h0;
            m_started = 1'b1;
        end else if (Flush) begin
            m_pc    = nxt;
            m_instr = 32'h0;
            m_pcp4  = 32'h0;
            m_valid = 1'b0;
        end else if (!Stall) begin
            m_pc    = nxt;
            m_instr = ins;
            m_pcp4  = p4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("pc", PC, m_pc);
            check("inst_address", {1'b0, InstAddress}, {1'b0, m_pc[30:0]});
            check("ifid_instr", IF_ID_Instruction, m_instr);
            check("ifid_pcplus4", IF_ID_PCPlus4, m_pcp4);
            check("ifid_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
            check("fetch_count", FetchCount, m_count);
        end
    end

    task automatic step(input logic st, input logic fl, input logic [2:0] sel,
                        input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr);
        Stall        = st;
        Flush        = fl;
        PCSrc        = sel;
        BranchTarget = bt;
        JumpIndex    = ji;
        JrTarget     = jr;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] sel);
        step(1'b0, 1'b0, sel, 32'h0, 26'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 | i;
        reset = 1'b1;
        Stall = 1'b0; Flush = 1'b0; PCSrc = 3'd0;
        BranchTarget = 32'h0; JumpIndex = 26'h0; JrTarget = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        check("rst_pc", PC, 32'h8000_0000);
        check("rst_inst_address", {1'b0, InstAddress}, 32'h0);
        check("rst_valid", {31'd0, IF_ID_Valid}, 32'h0);
        check("rst_count", FetchCount, 32'h0);
        check("rst_instr", IF_ID_Instruction, 32'h0);
        reset = 1'b0;

        // free run
        run(3'd0);
        check("first_instr", IF_ID_Instruction, 32'hC0DE_0000);
        check("first_pcp4", IF_ID_PCPlus4, 32'h8000_0004);
        run(3'd0);
        check("pcp4_2", IF_ID_PCPlus4, 32'h8000_0008);
        run(3'd0);
        check("pcp4_3", IF_ID_PCPlus4, 32'h8000_000C);
        run(3'd0);
        check("pcp4_4", IF_ID_PCPlus4, 32'h8000_0010);
        check("valid_4", {31'd0, IF_ID_Valid}, 32'h1);
        check("count_4", FetchCount, 32'd4);

        // return to 8000_0008, then flushed branch to 0x68
        step(1'b0, 1'b1, 3'd3, 32'h0, 26'h0, 32'h8000_0008);
        check("jr_sup_pc", PC, 32'h8000_0008);
        step(1'b0, 1'b1, 3'd1, 32'h0000_0068, 26'h0, 32'h0);
        check("br_pc", PC, 32'h8000_0068);
        check("br_bubble_valid", {31'd0, IF_ID_Valid}, 32'h0);
        check("br_bubble_instr", IF_ID_Instruction, 32'h0);
        check("br_count_hold", FetchCount, 32'd4);
        run(3'd0);
        check("br_word26", IF_ID_Instruction, 32'hC0DE_001A);
        check("br_count", FetchCount, 32'd5);

        // stall three edges at 8000_0010; PCSrc must be ignored
        step(1'b0, 1'b1, 3'd1, 32'h0000_0010, 26'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 3'd1, 32'h0000_0500, 26'h0, 32'h0);
            check("stall_pc", PC, 32'h8000_0010);
            check("stall_count", FetchCount, 32'd5);
        end
        run(3'd0);
        check("unstall_pc", PC, 32'h8000_0014);
        check("unstall_instr", IF_ID_Instruction, 32'hC0DE_0004);

        // JR cannot re-enter supervisor mode
        step(1'b0, 1'b1, 3'd1, 32'h0000_0040, 26'h0, 32'h0);
        step(1'b0, 1'b0, 3'd3, 32'h0, 26'h0, 32'h0000_0100);
        check("jr_user_pc", PC, 32'h0000_0100);
        step(1'b0, 1'b0, 3'd3, 32'h0, 26'h0, 32'h8000_0000);
        check("jr_nosup_pc", PC, 32'h0000_0000);

        // vectors and jump from user mode
        step(1'b0, 1'b0, 3'd1, 32'h0000_0020, 26'h0, 32'h0);
        check("user_pc", PC, 32'h0000_0020);
        run(3'd5);
        check("xadr_pc", PC, 32'h8000_0008);
        run(3'd7);
        check("illop7_pc", PC, 32'h8000_0004);
        run(3'd6);
        check("illop6_pc", PC, 32'h8000_0004);
        step(1'b0, 1'b0, 3'd3, 32'h0, 26'h0, 32'h0000_0020);
        step(1'b0, 1'b0, 3'd2, 32'h0, 26'h1b, 32'h0);
        check("jump_pc", PC, 32'h0000_006C);

        // misaligned target, then PC+4 wrap inside bits 30:0
        step(1'b0, 1'b0, 3'd1, 32'hFFFF_0133, 26'h0, 32'h0);
        check("align_pc", PC, 32'h7FFF_0130);
        step(1'b0, 1'b0, 3'd3, 32'h0, 26'h0, 32'hFFFF_FFFC);
        check("wrap_pre_pc", PC, 32'h7FFF_FFFC);
        run(3'd0);
        check("wrap_pc", PC, 32'h0000_0000);
        check("wrap_pcp4", IF_ID_PCPlus4, 32'h0000_0000);

        // stall and flush together, then reset during stall
        step(1'b1, 1'b1, 3'd2, 32'h0, 26'h10, 32'h0);
        check("sf_pc", PC, 32'h0000_0040);
        check("sf_valid", {31'd0, IF_ID_Valid}, 32'h0);
        reset = 1'b1;
        step(1'b1, 1'b0, 3'd1, 32'h0000_0200, 26'h0, 32'h0);
        check("rst2_pc", PC, 32'h8000_0000);
        check("rst2_count", FetchCount, 32'h0);
        check("rst2_pcp4", IF_ID_PCPlus4, 32'h0);
        reset = 1'b0;
        run(3'd0);
        check("post_rst_instr", IF_ID_Instruction, 32'hC0DE_0000);
        check("post_rst_count", FetchCount, 32'd1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
